// File: rtl/seqsum_pkg.sv
// Shared types and defaults for the step-2 series feeder.
package seqsum_pkg;

  localparam int DEPTH_DEF = 4;
  localparam int LAT_DEF   = 2;
  localparam int W_DEF     = 32;
  // Widest operand the pair struct carries; narrower W keeps only the low bits.
  localparam int PAIR_W    = 64;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT,
    ST_RESP
  } state_t;

  typedef struct packed {
    logic [PAIR_W-1:0] a;
    logic [PAIR_W-1:0] b;
  } pair_t;

endpackage

// File: rtl/seqsum_feed_if.sv
// Operand intake, sum-stage launch and result handshake bundle for seqsum_feed.
interface seqsum_feed_if #(
  parameter int W = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic [W-1:0] out_a;
  logic [W-1:0] out_b;
  logic         out_start;
  logic [W-1:0] sum_y;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] res_y;
  logic         res_err;

  modport master (
    output in_valid, in_a, in_b, sum_y, res_ready,
    input  in_ready, out_a, out_b, out_start, res_valid, res_y, res_err
  );

  modport slave (
    input  in_valid, in_a, in_b, sum_y, res_ready,
    output in_ready, out_a, out_b, out_start, res_valid, res_y, res_err
  );
endinterface

// File: rtl/seqsum_fifo.sv
// Synchronous operand-pair FIFO; full is registered so it can drive ready directly.
module seqsum_fifo
  import seqsum_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  push,
  input  pair_t wr_data,
  input  logic  pop,
  output pair_t rd_data,
  output logic  full,
  output logic  empty
);
  localparam int AW = $clog2(DEPTH);

  pair_t         mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]   count_reg, count_next;
  logic          full_reg;
  logic          do_push, do_pop;

  assign do_push = push && !full_reg;
  assign do_pop  = pop && (count_reg != '0);

  always_comb begin
    count_next = count_reg;
    if (do_push && !do_pop) begin
      count_next = count_reg + (AW+1)'(1);
    end else if (!do_push && do_pop) begin
      count_next = count_reg - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      full_reg   <= 1'b0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_next;
      full_reg  <= (count_next == (AW+1)'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= wr_data;
  end

  assign rd_data = mem[rd_ptr_reg];
  assign full    = full_reg;
  assign empty   = (count_reg == '0);
endmodule

// File: rtl/seqsum_feed.sv
// Feeds buffered (a,b) pairs to an external step-2 series summer and returns results in order.
// SEQSUM_FEED_SWAP_EN: swap reversed ranges instead of flagging them as empty.
module seqsum_feed
  import seqsum_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int W     = W_DEF,
  parameter int LAT   = LAT_DEF
) (
  input logic          clk,
  input logic          rst,
  seqsum_feed_if.slave bus
);
`ifdef SEQSUM_FEED_SWAP_EN
  localparam bit SWAP_EN = 1'b1;
`else
  localparam bit SWAP_EN = 1'b0;
`endif

  state_t       state_reg, state_next;
  pair_t        push_pair, head_pair;
  logic         fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [W-1:0] head_a, head_b;
  logic [W-1:0] out_a_reg, out_b_reg, res_y_reg, cnt_reg;
  logic [W-1:0] span, n_terms;
  logic         res_err_reg, head_ordered;

  assign push_pair = '{a: PAIR_W'(bus.in_a), b: PAIR_W'(bus.in_b)};
  assign fifo_push = bus.in_valid && bus.in_ready;
  assign fifo_pop  = (state_reg == ST_IDLE) && !fifo_empty;

  seqsum_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (fifo_push),
    .wr_data (push_pair),
    .pop     (fifo_pop),
    .rd_data (head_pair),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign head_a       = W'(head_pair.a);
  assign head_b       = W'(head_pair.b);
  assign head_ordered = (head_a <= head_b);
  // out_a <= out_b is guaranteed here, so the span never wraps and n fits in W bits.
  assign span         = out_b_reg - out_a_reg;
  assign n_terms      = (span >> 1) + W'(1);

  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (!fifo_empty) state_next = (head_ordered || SWAP_EN) ? ST_LAUNCH : ST_RESP;
      ST_LAUNCH: state_next = ST_WAIT;
      ST_WAIT:   if (cnt_reg == W'(1)) state_next = ST_RESP;
      ST_RESP:   if (bus.res_ready) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.out_start = 1'b0;
    bus.res_valid = 1'b0;
    if (!rst) begin
      bus.out_start = (state_reg == ST_LAUNCH);
      bus.res_valid = (state_reg == ST_RESP);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_a_reg   <= '0;
      out_b_reg   <= '0;
      cnt_reg     <= '0;
      res_y_reg   <= '0;
      res_err_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (!fifo_empty) begin
            if (head_ordered) begin
              out_a_reg <= head_a;
              out_b_reg <= head_b;
            end else if (SWAP_EN) begin
              out_a_reg <= head_b;
              out_b_reg <= head_a;
            end else begin
              res_y_reg   <= '0;
              res_err_reg <= 1'b1;
            end
          end
        end
        ST_LAUNCH: cnt_reg <= n_terms + W'(LAT);
        ST_WAIT: begin
          if (cnt_reg == W'(1)) begin
            res_y_reg   <= bus.sum_y;
            res_err_reg <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg - W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready = !fifo_full && !rst;
  assign bus.out_a    = out_a_reg;
  assign bus.out_b    = out_b_reg;
  assign bus.res_y    = res_y_reg;
  assign bus.res_err  = res_err_reg;
endmodule

// File: tb/tb_seqsum_feed.sv
// Directed bench for seqsum_feed with a behavioural step-2 series summer.
module tb_seqsum_feed;
  localparam int W     = 32;
  localparam int DEPTH = 4;
  localparam int LAT   = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seqsum_feed_if #(.W(W)) bus ();

  seqsum_feed #(.DEPTH(DEPTH), .W(W), .LAT(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int starts = 0;
  int start_cyc = 0;
  int rv_cyc = 0;
  int push_cyc = 0;
  int hs_cyc = 0;
  bit rv_prev = 1'b0;

  // Sum stage: accumulates one term per cycle after out_start.
  logic [W-1:0] term = '0;
  logic [W-1:0] acc  = '0;
  logic [W-1:0] rem  = '0;
  assign bus.sum_y = acc;

  always @(posedge clk) begin
    if (bus.out_start) begin
      term <= bus.out_a;
      acc  <= '0;
      rem  <= ((bus.out_b - bus.out_a) >> 1) + 32'd1;
    end else if (rem != '0) begin
      acc  <= acc + term;
      term <= term + 32'd2;
      rem  <= rem - 32'd1;
    end
  end

  always @(negedge clk) begin
    cyc++;
    if (bus.out_start) begin
      starts++;
      start_cyc = cyc;
    end
    if (bus.res_valid && !rv_prev) rv_cyc = cyc;
    rv_prev = bus.res_valid;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b);
    int t = 0;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    check_eq("push_wait", 32'(t < 300), 32'd1);
    push_cyc = cyc;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic get_result(input string tag, input logic [31:0] ey, input logic [31:0] eerr);
    int t = 0;
    bus.res_ready = 1'b1;
    while (!bus.res_valid && t < 800) begin
      @(negedge clk);
      t++;
    end
    check_eq({tag, "_wait"}, 32'(t < 800), 32'd1);
    check_eq({tag, "_y"}, bus.res_y, ey);
    check_eq({tag, "_err"}, 32'(bus.res_err), eerr);
    $display("txn %s: res_y=%0d res_err=%0d (want %0d/%0d)", tag, bus.res_y, bus.res_err, ey, eerr);
    hs_cyc = cyc;
    @(negedge clk);
    bus.res_ready = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
    check_eq({tag, "_res_valid"}, 32'(bus.res_valid), 32'd0);
    check_eq({tag, "_out_start"}, 32'(bus.out_start), 32'd0);
    check_eq({tag, "_res_y"}, bus.res_y, 32'd0);
    check_eq({tag, "_res_err"}, 32'(bus.res_err), 32'd0);
    check_eq({tag, "_out_a"}, bus.out_a, 32'd0);
    check_eq({tag, "_out_b"}, bus.out_b, 32'd0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    int first_hs;
    int t;
    bit seen;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.res_ready = 1'b0;

    repeat (3) @(negedge clk);
    check_reset_outputs("rst0");
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst0_ready_after", 32'(bus.in_ready), 32'd1);

    // a=1,b=10: 1+3+5+7+9 over n=5 terms, 7 WAIT cycles
    s0 = starts;
    push(32'd1, 32'd10);
    get_result("a1b10", 32'd25, 32'd0);
    check_eq("a1b10_starts", 32'(starts - s0), 32'd1);
    check_eq("a1b10_wait_cycles", 32'(rv_cyc - start_cyc - 1), 32'd7);

    s0 = starts;
    push(32'd7, 32'd7);
    get_result("a7b7", 32'd7, 32'd0);
    check_eq("a7b7_starts", 32'(starts - s0), 32'd1);
    check_eq("a7b7_wait_cycles", 32'(rv_cyc - start_cyc - 1), 32'd3);

    push(32'd0, 32'd1);
    get_result("a0b1", 32'd0, 32'd0);

    s0 = starts;
    push(32'd10, 32'd1);
`ifdef SEQSUM_FEED_SWAP_EN
    get_result("a10b1", 32'd25, 32'd0);
    check_eq("a10b1_starts", 32'(starts - s0), 32'd1);
`else
    get_result("a10b1", 32'd0, 32'd1);
    check_eq("a10b1_starts", 32'(starts - s0), 32'd0);
`endif

    // Backpressure: one in flight, four buffered, sixth held off
    push(32'd1, 32'd10);
    push(32'd7, 32'd7);
    push(32'd2, 32'd6);
    push(32'd0, 32'd1);
    push(32'd3, 32'd9);
    repeat (3) @(negedge clk);
    check_eq("full_in_ready", 32'(bus.in_ready), 32'd0);
    first_hs = 0;
    fork
      push(32'd4, 32'd8);
      begin
        get_result("q0", 32'd25, 32'd0);
        first_hs = hs_cyc;
        get_result("q1", 32'd7, 32'd0);
        get_result("q2", 32'd12, 32'd0);
        get_result("q3", 32'd0, 32'd0);
        get_result("q4", 32'd24, 32'd0);
        get_result("q5", 32'd18, 32'd0);
      end
    join
    check_eq("sixth_after_pop", 32'(push_cyc > first_hs), 32'd1);

    // Reset in the middle of a long WAIT
    s0 = starts;
    push(32'd1, 32'd1001);
    t = 0;
    while (starts == s0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    check_eq("long_launch", 32'(t < 50), 32'd1);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("rst1_no_start", 32'(bus.out_start), 32'd0);
    @(negedge clk);
    check_reset_outputs("rst1");
    rst = 1'b0;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      seen |= bus.res_valid;
    end
    check_eq("rst1_no_result", 32'(seen), 32'd0);
    push(32'd2, 32'd6);
    get_result("a2b6", 32'd12, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
